// File: rtl/cache_fill_ctrl.sv
// Cache line fill controller: on a miss, fetch the 8-word line from memory,
// write each returned word into the data array, then write the tag entry.
module cache_fill_ctrl (
    input  logic         clk,
    input  logic         rst,
    input  logic         miss_detected,
    input  logic [15:0]  miss_address,
    input  logic         mem_data_valid,
    input  logic [15:0]  mem_data_in,
    output logic         fsm_busy,
    output logic         mem_req,
    output logic [15:0]  mem_addr,
    output logic [127:0] block_enable,
    output logic [7:0]   word_enable,
    output logic         data_write,
    output logic [15:0]  mem_data_out,
    output logic         meta_write,
    output logic [7:0]   meta_out,
    output logic         fill_done
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        FILL      = 2'd1,
        WRITE_TAG = 2'd2
    } state_e;

    state_e     state_q, state_d;
    logic [4:0] tag_q, tag_d;
    logic [6:0] index_q, index_d;
    logic [3:0] issue_cnt_q, issue_cnt_d;
    logic [3:0] recv_cnt_q, recv_cnt_d;

    // The byte offset within the line never influences the fill.
    logic unused_offset;
    assign unused_offset = ^miss_address[3:0];

    always_comb begin
        state_d     = state_q;
        tag_d       = tag_q;
        index_d     = index_q;
        issue_cnt_d = issue_cnt_q;
        recv_cnt_d  = recv_cnt_q;
        case (state_q)
            IDLE: begin
                if (miss_detected) begin
                    state_d     = FILL;
                    tag_d       = miss_address[15:11];
                    index_d     = miss_address[10:4];
                    issue_cnt_d = 4'd0;
                    recv_cnt_d  = 4'd0;
                end
            end
            FILL: begin
                if (issue_cnt_q != 4'd8) issue_cnt_d = issue_cnt_q + 4'd1;
                if (mem_data_valid) begin
                    if (recv_cnt_q != 4'd8) recv_cnt_d = recv_cnt_q + 4'd1;
                    if (recv_cnt_q == 4'd7) state_d = WRITE_TAG;
                end
            end
            WRITE_TAG: state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            tag_q       <= 5'd0;
            index_q     <= 7'd0;
            issue_cnt_q <= 4'd0;
            recv_cnt_q  <= 4'd0;
        end else begin
            state_q     <= state_d;
            tag_q       <= tag_d;
            index_q     <= index_d;
            issue_cnt_q <= issue_cnt_d;
            recv_cnt_q  <= recv_cnt_d;
        end
    end

    // Everything except the data-write path decodes straight from flops;
    // data_write must track mem_data_valid in the same cycle.
    always_comb begin
        fsm_busy     = (state_q != IDLE);
        mem_req      = (state_q == FILL) && (issue_cnt_q != 4'd8);
        mem_addr     = mem_req ? {tag_q, index_q, issue_cnt_q[2:0], 1'b0} : 16'd0;
        block_enable = fsm_busy ? (128'd1 << index_q) : 128'd0;
        data_write   = (state_q == FILL) && mem_data_valid;
        word_enable  = data_write ? (8'd1 << recv_cnt_q[2:0]) : 8'd0;
        mem_data_out = mem_data_in;
        meta_write   = (state_q == WRITE_TAG);
        fill_done    = meta_write;
        meta_out     = meta_write ? {1'b1, 2'b00, tag_q} : 8'd0;
    end

endmodule

// File: tb/tb_cache_fill_ctrl.sv
// Randomized and directed bench for cache_fill_ctrl against a line-fill
// reference model, with a simple latency-queue memory responder.
module tb_cache_fill_ctrl;

    logic         clk = 1'b0;
    logic         rst, miss_detected, mem_data_valid;
    logic [15:0]  miss_address, mem_data_in;
    logic         fsm_busy, mem_req, data_write, meta_write, fill_done;
    logic [15:0]  mem_addr, mem_data_out;
    logic [127:0] block_enable;
    logic [7:0]   word_enable, meta_out;

    cache_fill_ctrl dut (
        .clk(clk), .rst(rst), .miss_detected(miss_detected), .miss_address(miss_address),
        .mem_data_valid(mem_data_valid), .mem_data_in(mem_data_in), .fsm_busy(fsm_busy),
        .mem_req(mem_req), .mem_addr(mem_addr), .block_enable(block_enable),
        .word_enable(word_enable), .data_write(data_write), .mem_data_out(mem_data_out),
        .meta_write(meta_write), .meta_out(meta_out), .fill_done(fill_done)
    );

    always #5 clk = ~clk;

    int n_vec = 0, n_err = 0, cyc = 0;
    int pend[$];
    int lat = 4, gap_idx = 0, spur_pct = 0, gate_pct = 100, busy_cnt = 0;
    bit gap_en = 0, force_v = 0;
    bit s_rst = 1, s_miss = 0;
    logic [15:0] s_addr = 16'd0;
    logic [15:0]  addr_log[$];
    logic [7:0]   we_log[$], meta_log[$];
    logic [127:0] blk_log[$];

    // Reference model: a fill in flight is described by its line base address,
    // how many words were requested and how many came back.
    bit          m_active = 0, m_tag = 0;
    logic [15:0] m_base = 16'd0;
    int          m_issued = 0, m_recv = 0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic clear_logs();
        addr_log.delete(); we_log.delete(); meta_log.delete(); blk_log.delete();
        busy_cnt = 0;
    endtask

    task automatic cycle();
        bit v, gate, e_req, e_dw;
        logic [15:0] d;
        @(posedge clk); #1;
        if (mem_req === 1'b1) pend.push_back(cyc + lat);
        gate = ($urandom_range(0, 99) < gate_pct);
        if (gap_en) begin
            gate = ((gap_idx % 5) inside {0, 2, 3});
            gap_idx++;
        end
        v = 0;
        if (pend.size() > 0 && pend[0] <= cyc && gate) begin
            v = 1;
            pend.delete(0);
        end
        if (force_v) v = 1;
        if ($urandom_range(0, 99) < spur_pct) v = 1;
        d = 16'($urandom);
        rst = s_rst; miss_detected = s_miss; miss_address = s_addr;
        mem_data_valid = v; mem_data_in = d;
        #3;
        e_req = m_active && !m_tag && (m_issued < 8);
        e_dw  = m_active && !m_tag && v;
        chk("busy",     fsm_busy,     m_active);
        chk("mem_req",  mem_req,      e_req);
        chk("mem_addr", mem_addr,     e_req ? m_base + 16'(2 * m_issued) : 16'd0);
        chk("blk_en",   block_enable, m_active ? (128'd1 << m_base[10:4]) : 128'd0);
        chk("dwrite",   data_write,   e_dw);
        chk("word_en",  word_enable,  e_dw ? (8'd1 << m_recv) : 8'd0);
        chk("mdata",    mem_data_out, d);
        chk("mwrite",   meta_write,   m_tag);
        chk("done",     fill_done,    m_tag);
        chk("meta",     meta_out,     m_tag ? (8'h80 | 8'(m_base[15:11])) : 8'd0);
        if (mem_req === 1'b1) addr_log.push_back(mem_addr);
        if (data_write === 1'b1) we_log.push_back(word_enable);
        if (meta_write === 1'b1) begin
            meta_log.push_back(meta_out);
            blk_log.push_back(block_enable);
        end
        if (fsm_busy === 1'b1) busy_cnt++;
        if (s_rst) begin
            m_active = 0; m_tag = 0; m_base = 16'd0; m_issued = 0; m_recv = 0;
            pend.delete();
        end else if (!m_active) begin
            if (s_miss) begin
                m_active = 1; m_base = s_addr & 16'hFFF0; m_issued = 0; m_recv = 0;
            end
        end else if (m_tag) begin
            m_active = 0; m_tag = 0;
        end else begin
            if (m_issued < 8) m_issued++;
            if (v) begin
                m_recv++;
                if (m_recv == 8) m_tag = 1;
            end
        end
        cyc++;
    endtask

    task automatic wait_idle(input int max);
        int n = 0;
        while (m_active && n < max) begin
            cycle();
            n++;
        end
        chk("fill_timeout", m_active, 1'b0);
    endtask

    task automatic start_fill(input logic [15:0] a);
        s_miss = 1; s_addr = a;
        cycle();
        s_miss = 0;
    endtask

    initial begin
        rst = 1; miss_detected = 0; miss_address = 0; mem_data_valid = 0; mem_data_in = 0;
        repeat (2) cycle();
        s_rst = 0;

        // Nominal fill with fixed latency 4
        clear_logs(); lat = 4;
        start_fill(16'hA5C6);
        wait_idle(60);
        chk("busy_cycles", 128'(busy_cnt), 128'd13);
        chk("n_addr", 128'(addr_log.size()), 128'd8);
        for (int i = 0; i < 8 && i < addr_log.size(); i++)
            chk("seq_addr", addr_log[i], 16'hA5C0 + 16'(2 * i));
        chk("n_words", 128'(we_log.size()), 128'd8);
        for (int i = 0; i < 8 && i < we_log.size(); i++)
            chk("seq_we", we_log[i], 8'd1 << i);
        chk("meta_a5c6", (meta_log.size() > 0) ? meta_log[0] : 8'hxx, 8'h94);
        chk("blk_a5c6", (blk_log.size() > 0) ? blk_log[0] : 128'hx, 128'd1 << 8'h5C);

        // Gapped valid pattern
        clear_logs(); lat = 2; gap_en = 1; gap_idx = 0;
        start_fill(16'h3210);
        wait_idle(80);
        gap_en = 0;
        chk("gap_words", 128'(we_log.size()), 128'd8);
        for (int i = 0; i < 8 && i < we_log.size(); i++)
            chk("gap_we", we_log[i], 8'd1 << i);
        chk("gap_meta_n", 128'(meta_log.size()), 128'd1);

        // Miss held high with a changing address
        clear_logs(); lat = 3;
        s_miss = 1; s_addr = 16'h1234;
        cycle();
        s_addr = 16'h7770;
        wait_idle(60);
        chk("hold_meta_n", 128'(meta_log.size()), 128'd1);
        cycle();
        s_miss = 0;
        wait_idle(60);
        chk("hold_meta_n2", 128'(meta_log.size()), 128'd2);
        if (meta_log.size() == 2) begin
            chk("hold_meta0", meta_log[0], 8'h82);
            chk("hold_meta1", meta_log[1], 8'h8E);
        end
        if (addr_log.size() > 8) chk("hold_addr2", addr_log[8], 16'h7770);

        // Reset after the third received word
        clear_logs(); lat = 4;
        start_fill(16'h4C80);
        for (int n = 0; n < 40 && m_recv < 3; n++) cycle();
        chk("pre_rst_recv", 128'(m_recv), 128'd3);
        s_rst = 1;
        cycle();
        s_rst = 0;
        cycle();
        chk("rst_busy", fsm_busy, 1'b0);
        chk("rst_req", mem_req, 1'b0);
        chk("rst_meta_n", 128'(meta_log.size()), 128'd0);
        clear_logs();
        start_fill(16'h4C80);
        wait_idle(60);
        chk("refill_words", 128'(we_log.size()), 128'd8);
        if (we_log.size() > 0) chk("refill_we0", we_log[0], 8'h01);

        // Valid pulses while idle
        clear_logs(); force_v = 1;
        repeat (3) cycle();
        force_v = 0;
        chk("idle_valid_dw", 128'(we_log.size()), 128'd0);
        chk("idle_valid_busy", 128'(busy_cnt), 128'd0);

        // Back-to-back corner addresses
        clear_logs(); lat = 1;
        start_fill(16'h0000);
        wait_idle(60);
        start_fill(16'hFFFE);
        wait_idle(60);
        chk("b2b_meta_n", 128'(meta_log.size()), 128'd2);
        if (meta_log.size() == 2) begin
            chk("b2b_meta0", meta_log[0], 8'h80);
            chk("b2b_meta1", meta_log[1], 8'h9F);
            chk("b2b_blk0", blk_log[0], 128'd1);
            chk("b2b_blk1", blk_log[1], 128'd1 << 127);
        end

        // Randomized traffic
        spur_pct = 5; gate_pct = 80;
        for (int i = 0; i < 3000; i++) begin
            s_rst  = ($urandom_range(0, 299) == 0);
            s_miss = ($urandom_range(0, 5) == 0);
            s_addr = 16'($urandom);
            if ($urandom_range(0, 19) == 0) lat = $urandom_range(1, 6);
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/cache_fill_ctrl.md
CACHE_FILL_CTRL -- requirements
Module: cache_fill_ctrl

Interface
REQ-001: clk  in  1  system clock; all state updates on rising edge.
REQ-002: rst  in  1  reset, synchronous, active-high.
REQ-003: miss_detected  in  1  cache miss on miss_address this cycle.
REQ-004: miss_address  in  16  byte address of miss: tag [15:11], index [10:4], offset [3:0].
REQ-005: mem_data_valid  in  1  memory returning one 16-bit word this cycle.
REQ-006: mem_data_in  in  16  returned memory word.
REQ-007: fsm_busy  out  1  fill in progress; pipeline stalls while high.
REQ-008: mem_req  out  1  read request to memory this cycle.
REQ-009: mem_addr  out  16  word-aligned address of current request.
REQ-010: block_enable  out  128  one-hot line select for data and tag arrays.
REQ-011: word_enable  out  8  one-hot word select within line for data write.
REQ-012: data_write  out  1  write mem_data_out into data array this cycle.
REQ-013: mem_data_out  out  16  combinational copy of mem_data_in.
REQ-014: meta_write  out  1  write meta_out into tag array this cycle.
REQ-015: meta_out  out  8  {valid=1, 2'b00, tag[4:0]}.
REQ-016: fill_done  out  1  one-cycle pulse at fill completion.

Function
REQ-017: States IDLE, FILL, WRITE_TAG; encoding free, no other reachable states.
REQ-018: IDLE & miss_detected -> FILL; capture tag, index; issue_cnt=0, recv_cnt=0.
REQ-019: miss_detected ignored outside IDLE; no second capture.
REQ-020: mem_data_valid in IDLE or WRITE_TAG ignored: no data_write, counters unchanged.
REQ-021: FILL, issue_cnt<8: mem_req=1, mem_addr={tag,index,issue_cnt[2:0],1'b0}, issue_cnt+1; first request in the cycle after capture.
REQ-022: FILL, issue_cnt==8: mem_req=0, mem_addr=0.
REQ-023: FILL & mem_data_valid: data_write=1, word_enable=one-hot(recv_cnt), recv_cnt+1; issue and receive may happen in the same cycle.
REQ-024: Memory latency is external; controller never assumes a fixed count, only counts mem_data_valid.
REQ-025: FILL & mem_data_valid & recv_cnt==7 -> WRITE_TAG; final data_write happens that cycle.
REQ-026: WRITE_TAG: meta_write=1, fill_done=1, meta_out per REQ-015, then -> IDLE; lasts one cycle.
REQ-027: block_enable=one-hot(captured index) in FILL and WRITE_TAG, all-zero in IDLE.
REQ-028: fsm_busy=1 in FILL and WRITE_TAG, 0 in IDLE; goes high the cycle after miss_detected is accepted.
REQ-029: word_enable=0 whenever data_write=0; meta_out=0 whenever meta_write=0.
REQ-030: At most one of data_write, meta_write is high per cycle.
REQ-031: Counters are 4 bits and saturate at 8; they never wrap during a fill.

Reset
REQ-032: rst=1 -> state IDLE, counters 0, captured tag/index 0 on next edge, overriding all other inputs.
REQ-033: Reset values: fsm_busy, mem_req, data_write, meta_write, fill_done = 0; mem_addr, block_enable, word_enable, meta_out = 0.
REQ-034: Reset mid-fill aborts the fill with no meta_write; the partially written line stays invalid.
REQ-035: IDLE & miss_detected in the first cycle after rst deasserts is accepted normally.

Verification
REQ-036: miss 0xA5C6, memory returns data 4 cycles after each request -> mem_addr 0xA5C0..0xA5CE (step 2) on 8 consecutive cycles; block_enable bit 0x5C; 8 data_writes with word_enable 0x01..0x80; meta_write with meta_out=0x94; fill_done pulse; busy for 8+4+1 cycles.
REQ-037: valid gaps (pattern 1,0,1,1,0...) -> exactly 8 data_writes in order; WRITE_TAG only after the 8th valid.
REQ-038: miss_detected held high through whole fill with a different address -> one fill only, for the first address; a new fill starts the cycle after return to IDLE if miss is still high.
REQ-039: rst asserted after 3rd received word -> next cycle all outputs 0, state IDLE, no meta_write; a later miss refills from word 0.
REQ-040: mem_data_valid pulsed in IDLE -> no data_write, no state change.
REQ-041: back-to-back misses 0x0000 then 0xFFFE -> block_enable bit 0 then bit 127; meta_out 0x80 then 0x9F.
